// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the register-file write-back path.
//   XLEN  - write-port data width
//   NREG  - number of architectural registers (x0 included)
//   CNTW  - width of each per-register pending-write counter
//   wb_req_t - one write-back request (valid, destination, data)
//   wb_src_e - write-back requester identity, also used as the arbiter pointer
package wb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned CNTW = 2;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write counters for the issue stall.
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   inc_en_i, inc_rd_i   - an issued instruction reserves a write to inc_rd_i
//   dec_en_i, dec_rd_i   - the write port retires a write to dec_rd_i
//   rs1_i, rs2_i, rd_i   - register indices of the instruction at issue
//   rs1_busy_o           - rs1 has at least one pending write
//   rs2_busy_o           - rs2 has at least one pending write
//   rd_full_o            - rd counter is saturated; one more reservation would overflow
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned CNTW = wb_pkg::CNTW
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_en_i,
  input  logic [4:0] inc_rd_i,
  input  logic       dec_en_i,
  input  logic [4:0] dec_rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o,
  output logic       rd_full_o
);

  // Entry 0 exists only so x0 reads as zero; it is never changed.
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [NREG-1:0] inc_hit;
  logic [NREG-1:0] dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (inc_en_i) inc_hit[inc_rd_i] = 1'b1;
    if (dec_en_i) dec_hit[dec_rd_i] = 1'b1;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (inc_hit[r] && !dec_hit[r]) begin
          cnt_d[r] = cnt_q[r] + 1'b1;
        end else if (dec_hit[r] && !inc_hit[r] && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rs1_busy_o = (cnt_q[rs1_i] != '0);
  assign rs2_busy_o = (cnt_q[rs2_i] != '0);
  assign rd_full_o  = (cnt_q[rd_i] == '1);

  // A retiring write must have been reserved at issue.
  dec_of_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dec_en_i |-> (cnt_q[dec_rd_i] != '0));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back controller for the 32-entry register file.
//   clk, rst                         - clock, synchronous active-low reset
//   exu_valid/ready, exu_rd/data     - execute-unit write-back request
//   lsu_valid/ready, lsu_rd/data     - load/store-unit write-back request
//   iss_valid, iss_wb, iss_rd/rs1/rs2 - instruction presented for issue
//   iss_stall                        - issue must hold (combinational)
//   RegWEn, addr_towrite, data_towrite - registered register-file write port
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = wb_pkg::XLEN,
  parameter int unsigned CNTW = wb_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic            iss_wb,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  output logic            iss_stall,
  output logic            RegWEn,
  output logic [4:0]      addr_towrite,
  output logic [XLEN-1:0] data_towrite
);

  wb_src_e         ptr_q, ptr_d;
  logic            wen_q, wen_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            exu_gnt, lsu_gnt;
  logic            rs1_busy, rs2_busy, rd_full;
  logic            iss_inc;

  // Grants are gated by rst so neither requester is accepted during reset.
  always_comb begin
    exu_gnt = rst && exu_valid && (!lsu_valid || (ptr_q == SRC_EXU));
    lsu_gnt = rst && lsu_valid && (!exu_valid || (ptr_q == SRC_LSU));

    ptr_d = ptr_q;
    if (exu_valid && lsu_valid) begin
      ptr_d = exu_gnt ? SRC_LSU : SRC_EXU;
    end

    // x0 writes are accepted and latched but never enable the port.
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (exu_gnt) begin
      wen_d  = (exu_rd != '0);
      addr_d = exu_rd;
      data_d = exu_data;
    end else if (lsu_gnt) begin
      wen_d  = (lsu_rd != '0);
      addr_d = lsu_rd;
      data_d = lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= SRC_EXU;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign exu_ready    = exu_gnt;
  assign lsu_ready    = lsu_gnt;
  assign RegWEn       = wen_q;
  assign addr_towrite = addr_q;
  assign data_towrite = data_q;

  assign iss_stall = rst && iss_valid && (rs1_busy || rs2_busy || (iss_wb && rd_full));
  assign iss_inc   = iss_valid && !iss_stall && iss_wb && (iss_rd != '0);

  wb_scoreboard #(
    .CNTW(CNTW)
  ) u_scoreboard (
    .clk_i     (clk),
    .rst_ni    (rst),
    .inc_en_i  (iss_inc),
    .inc_rd_i  (iss_rd),
    .dec_en_i  (wen_q),
    .dec_rd_i  (addr_q),
    .rs1_i     (iss_rs1),
    .rs2_i     (iss_rs2),
    .rd_i      (iss_rd),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy),
    .rd_full_o (rd_full)
  );

endmodule
